// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory fetch controller: loads a program into a synchronous
// memory through a valid/ready loader port, then streams instructions out
// with stall, branch redirect and halt-opcode detection.
module imem_fetch_ctrl #(
  parameter int         MEM_SPACE = 8,
  parameter int         ISIZE     = 16,
  parameter logic [3:0] HALT_OP   = 4'hF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 load_start,
  input  logic                 load_valid,
  input  logic [ISIZE-1:0]     load_data,
  input  logic                 load_last,
  output logic                 load_ready,
  input  logic                 stall,
  input  logic                 br_taken,
  input  logic [MEM_SPACE-1:0] br_target,
  output logic [MEM_SPACE-1:0] mem_addr,
  output logic                 mem_we,
  output logic [ISIZE-1:0]     mem_wdata,
  input  logic [ISIZE-1:0]     mem_rdata,
  output logic [ISIZE-1:0]     inst,
  output logic [MEM_SPACE-1:0] inst_pc,
  output logic                 inst_valid,
  output logic                 halted,
  output logic                 busy_load
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FETCH = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t               state;
  logic [MEM_SPACE-1:0] fetch_pc;
  logic [MEM_SPACE-1:0] load_cnt;
  logic                 load_accept;
  logic                 is_halt_op;

  // The memory returns data one cycle after the address, so the instruction
  // is the read port itself and inst_pc tracks the address that produced it.
  assign inst        = mem_rdata;
  assign load_accept = (state == LOAD) && load_valid && load_ready;
  assign is_halt_op  = (mem_rdata[ISIZE-1 -: 4] == HALT_OP);

  // Memory port steering: loader writes in LOAD, re-read of inst_pc on stall.
  always_comb begin
    mem_addr  = fetch_pc;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state)
      LOAD: begin
        mem_addr = load_cnt;
        if (load_accept) begin
          mem_we    = 1'b1;
          mem_wdata = load_data;
        end
      end
      FETCH: begin
        mem_addr = stall ? inst_pc : fetch_pc;
      end
      default: begin
        mem_addr = fetch_pc;
      end
    endcase
  end

  // Control FSM with registered status flags and fetch pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      fetch_pc   <= '0;
      inst_pc    <= '0;
      load_cnt   <= '0;
      inst_valid <= 1'b0;
      load_ready <= 1'b0;
      halted     <= 1'b0;
      busy_load  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_start) begin
            state      <= LOAD;
            load_cnt   <= '0;
            fetch_pc   <= '0;
            load_ready <= 1'b1;
            busy_load  <= 1'b1;
          end else if (run) begin
            state <= FETCH;
          end
        end

        LOAD: begin
          if (load_accept) begin
            // Stop at the top address instead of letting the counter wrap.
            if (load_last || (load_cnt == '1)) begin
              state      <= IDLE;
              load_ready <= 1'b0;
              busy_load  <= 1'b0;
            end else begin
              load_cnt <= load_cnt + 1'b1;
            end
          end
        end

        FETCH: begin
          if (!run) begin
            state      <= IDLE;
            inst_valid <= 1'b0;
          end else if (br_taken) begin
            fetch_pc   <= br_target;
            inst_valid <= 1'b0;
          end else if (!stall) begin
            if (inst_valid && is_halt_op) begin
              state      <= HALT;
              halted     <= 1'b1;
              inst_valid <= 1'b0;
              fetch_pc   <= inst_pc;
            end else begin
              fetch_pc   <= fetch_pc + 1'b1;
              inst_pc    <= fetch_pc;
              inst_valid <= 1'b1;
            end
          end
        end

        HALT: begin
          if (load_start) begin
            state      <= LOAD;
            halted     <= 1'b0;
            load_cnt   <= '0;
            fetch_pc   <= '0;
            load_ready <= 1'b1;
            busy_load  <= 1'b1;
          end else if (!run) begin
            state  <= IDLE;
            halted <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: expected memory writes and delivered
// instructions are queued up front and a negedge monitor checks them.
module tb_imem_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        run;
  logic        load_start;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        stall;
  logic        br_taken;
  logic [7:0]  br_target;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [15:0] inst;
  logic [7:0]  inst_pc;
  logic        inst_valid;
  logic        halted;
  logic        busy_load;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } xact_t;

  xact_t       wq[$];
  xact_t       iq[$];
  logic [15:0] mem [256];
  logic [15:0] prog_b [6];
  int          checks;
  int          errors;

  imem_fetch_ctrl #(.MEM_SPACE(8), .ISIZE(16), .HALT_OP(4'hF)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .halted     (halted),
    .busy_load  (busy_load)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous memory model: write-enable and one-cycle read latency.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Drives one cycle of inputs just after the rising edge, returns at the falling edge.
  task automatic applyStimulus(input logic r, input logic ls, input logic lv, input logic ll,
                               input logic [15:0] ld, input logic st, input logic bt,
                               input logic [7:0] tgt);
    @(posedge clk);
    #1;
    run        = r;
    load_start = ls;
    load_valid = lv;
    load_last  = ll;
    load_data  = ld;
    stall      = st;
    br_taken   = bt;
    br_target  = tgt;
    @(negedge clk);
  endtask

  // Monitor: every memory write and every delivered instruction is matched in order.
  always @(negedge clk) begin
    xact_t e;
    if (rst) begin
      if (mem_we) begin
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_write: got addr %0h data %0h, expected no write", mem_addr, mem_wdata);
        end else begin
          e = wq.pop_front();
          checkOutput("write_addr", {24'd0, mem_addr}, {24'd0, e.addr});
          checkOutput("write_data", {16'd0, mem_wdata}, {16'd0, e.data});
        end
      end
      if (inst_valid && !stall) begin
        if (iq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_inst: got pc %0h inst %0h, expected none", inst_pc, inst);
        end else begin
          e = iq.pop_front();
          checkOutput("inst_pc", {24'd0, inst_pc}, {24'd0, e.addr});
          checkOutput("inst_data", {16'd0, inst}, {16'd0, e.data});
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] timeout");
  end

  // Directed stimulus sequence.
  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    run        = 1'b0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_data  = '0;
    stall      = 1'b0;
    br_taken   = 1'b0;
    br_target  = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    prog_b = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'hF000};

    // Reset state
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_inst_valid", inst_valid, 0);
    checkOutput("rst_load_ready", load_ready, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_busy_load", busy_load, 0);
    checkOutput("rst_inst_pc", inst_pc, 0);
    #24 rst = 1'b1;

    // Four-word load ending on load_last
    $display("[TB] four-word load");
    for (int i = 0; i < 4; i++) wq.push_back('{addr: 8'(i), data: 16'h1111 * 16'(i + 1)});
    applyStimulus(0, 1, 0, 0, 16'h0, 0, 0, 8'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 1, (i == 3), 16'h1111 * 16'(i + 1), 0, 0, 8'h0);
      if (i == 0) begin
        checkOutput("load4_busy", busy_load, 1);
        checkOutput("load4_ready", load_ready, 1);
      end
    end
    applyStimulus(0, 0, 0, 0, 16'h0, 0, 0, 8'h0);
    checkOutput("load4_done_busy", busy_load, 0);
    checkOutput("load4_done_ready", load_ready, 0);

    // Six-word program with a loader gap, halt opcode at address 5
    $display("[TB] program load with gap");
    for (int i = 0; i < 6; i++) wq.push_back('{addr: 8'(i), data: prog_b[i]});
    applyStimulus(0, 1, 0, 0, 16'h0, 0, 0, 8'h0);
    for (int i = 0; i < 6; i++) begin
      if (i == 3) applyStimulus(0, 0, 0, 0, 16'hBEEF, 0, 0, 8'h0);
      applyStimulus(0, 0, 1, (i == 5), prog_b[i], 0, 0, 8'h0);
    end
    applyStimulus(0, 0, 0, 0, 16'h0, 0, 0, 8'h0);
    checkOutput("loadb_done_busy", busy_load, 0);

    // Fetch stream with a three-cycle stall at pc 2 and halt at pc 5
    $display("[TB] fetch, stall, halt");
    for (int i = 0; i < 6; i++) iq.push_back('{addr: 8'(i), data: prog_b[i]});
    applyStimulus(1, 0, 0, 0, 16'h0, 0, 0, 8'h0);
    applyStimulus(1, 0, 0, 0, 16'h0, 0, 0, 8'h0);
    checkOutput("fetch_c1_valid", inst_valid, 0);
    applyStimulus(1, 0, 0, 0, 16'h0, 0, 0, 8'h0);
    checkOutput("fetch_c2_valid", inst_valid, 1);
    checkOutput("fetch_c2_pc", inst_pc, 0);
    applyStimulus(1, 0, 0, 0, 16'h0, 0, 0, 8'h0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 0, 0, 0, 16'h0, 1, 0, 8'h0);
      checkOutput("stall_valid", inst_valid, 1);
      checkOutput("stall_pc", inst_pc, 2);
      checkOutput("stall_inst", inst, 16'h3333);
    end
    applyStimulus(1, 0, 0, 0, 16'h0, 0, 0, 8'h0);
    checkOutput("resume_pc2", inst_pc, 2);
    applyStimulus(1, 0, 0, 0, 16'h0, 0, 0, 8'h0);
    checkOutput("resume_pc3", inst_pc, 3);
    applyStimulus(1, 0, 0, 0, 16'h0, 0, 0, 8'h0);
    applyStimulus(1, 0, 0, 0, 16'h0, 0, 0, 8'h0);
    checkOutput("halt_op_pc", inst_pc, 5);
    checkOutput("halt_op_halted", halted, 0);
    applyStimulus(1, 0, 0, 0, 16'h0, 0, 0, 8'h0);
    checkOutput("halt_halted", halted, 1);
    checkOutput("halt_valid", inst_valid, 0);
    applyStimulus(0, 0, 0, 0, 16'h0, 0, 0, 8'h0);
    checkOutput("halt_hold", halted, 1);
    applyStimulus(0, 0, 0, 0, 16'h0, 0, 0, 8'h0);
    checkOutput("halt_to_idle", halted, 0);
    checkOutput("idle_mem_we", mem_we, 0);

    // Full 256-word load without load_last, then a stray word is refused
    $display("[TB] full-range load");
    for (int i = 0; i < 256; i++) wq.push_back('{addr: 8'(i), data: 16'h1000 + 16'(i)});
    applyStimulus(0, 1, 0, 0, 16'h0, 0, 0, 8'h0);
    for (int i = 0; i < 256; i++) applyStimulus(0, 0, 1, 0, 16'h1000 + 16'(i), 0, 0, 8'h0);
    applyStimulus(0, 0, 1, 0, 16'h7777, 0, 0, 8'h0);
    checkOutput("full_done_busy", busy_load, 0);
    checkOutput("full_done_ready", load_ready, 0);
    checkOutput("full_done_we", mem_we, 0);
    applyStimulus(0, 0, 0, 0, 16'h0, 0, 0, 8'h0);

    // Branch to 0x40 together with stall, plus ignored load_start in FETCH
    $display("[TB] branch redirect");
    iq.push_back('{addr: 8'h00, data: 16'h1000});
    iq.push_back('{addr: 8'h40, data: 16'h1040});
    iq.push_back('{addr: 8'h41, data: 16'h1041});
    applyStimulus(1, 0, 0, 0, 16'h0, 0, 0, 8'h0);
    applyStimulus(1, 0, 0, 0, 16'h0, 0, 0, 8'h0);
    checkOutput("br_c1_valid", inst_valid, 0);
    applyStimulus(1, 1, 0, 0, 16'h0, 0, 0, 8'h0);
    applyStimulus(1, 0, 0, 0, 16'h0, 1, 1, 8'h40);
    checkOutput("fetch_ignores_load_start", busy_load, 0);
    applyStimulus(1, 0, 0, 0, 16'h0, 0, 0, 8'h0);
    checkOutput("br_bubble_valid", inst_valid, 0);
    checkOutput("br_bubble_addr", mem_addr, 8'h40);
    applyStimulus(1, 0, 0, 0, 16'h0, 0, 0, 8'h0);
    checkOutput("br_target_valid", inst_valid, 1);
    applyStimulus(0, 0, 0, 0, 16'h0, 0, 0, 8'h0);
    applyStimulus(0, 0, 0, 0, 16'h0, 0, 0, 8'h0);
    checkOutput("stop_valid", inst_valid, 0);

    // Reset in the middle of a load
    $display("[TB] reset during load");
    wq.push_back('{addr: 8'h00, data: 16'hABCD});
    wq.push_back('{addr: 8'h01, data: 16'hBCDE});
    applyStimulus(0, 1, 0, 0, 16'h0, 0, 0, 8'h0);
    applyStimulus(0, 0, 1, 0, 16'hABCD, 0, 0, 8'h0);
    applyStimulus(0, 0, 1, 0, 16'hBCDE, 0, 0, 8'h0);
    @(posedge clk);
    #1;
    load_valid = 1'b1;
    load_data  = 16'hDEAD;
    #1;
    checkOutput("preload_rst_we", mem_we, 1);
    #1 rst = 1'b0;
    #1;
    checkOutput("midload_rst_we", mem_we, 0);
    checkOutput("midload_rst_busy", busy_load, 0);
    checkOutput("midload_rst_ready", load_ready, 0);
    checkOutput("midload_rst_addr", mem_addr, 0);
    checkOutput("midload_rst_inst_pc", inst_pc, 0);
    load_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 16'h0, 0, 0, 8'h0);
    checkOutput("post_rst_busy", busy_load, 0);
    checkOutput("mem_not_written", mem[2], 16'h1002);

    checkOutput("write_queue_drained", wq.size(), 0);
    checkOutput("inst_queue_drained", iq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 SHALL have parameter MEM_SPACE, default 8, instruction-memory address width.
REQ-002 SHALL have parameter ISIZE, default 16, instruction word width.
REQ-003 SHALL have parameter HALT_OP, default 4'hF, opcode in inst[ISIZE-1:ISIZE-4] meaning halt.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset; asynchronous and active-low (rst==0 resets).
REQ-006 run  in  1  level request to execute; 1 starts/continues fetch, 0 stops it.
REQ-007 load_start  in  1  single-cycle pulse that starts program loading.
REQ-008 load_valid / load_data  in  1 / ISIZE  loader handshake, word to write.
REQ-009 load_last  in  1  qualifies the final loader word; sampled with load_valid.
REQ-010 load_ready  out  1  controller accepts a loader word this cycle.
REQ-011 stall  in  1  downstream cannot accept the instruction this cycle.
REQ-012 br_taken / br_target  in  1 / MEM_SPACE  redirect fetch to br_target.
REQ-013 mem_addr / mem_we / mem_wdata  out  MEM_SPACE / 1 / ISIZE  memory port; read data returns one cycle after mem_addr.
REQ-014 mem_rdata  in  ISIZE  memory read data.
REQ-015 inst / inst_pc / inst_valid  out  ISIZE / MEM_SPACE / 1  fetched instruction, its address, qualifier.
REQ-016 halted / busy_load  out  1 / 1  state flags.

Function
REQ-017 States SHALL be IDLE, LOAD, FETCH and HALT, one-hot or encoded.
REQ-018 IDLE: load_start -> LOAD (priority over run); else run==1 -> FETCH.
REQ-019 LOAD entry SHALL clear load counter and fetch_pc to 0; busy_load=1, load_ready=1.
REQ-020 LOAD: each load_valid&&load_ready cycle SHALL drive mem_we=1, mem_addr=load counter, mem_wdata=load_data, then increment the counter.
REQ-021 LOAD exits to IDLE after the accepted word with load_last=1 or the word written at address 2^MEM_SPACE-1, whichever first; counter never wraps.
REQ-022 mem_we SHALL be 0 in every state except an accepted LOAD cycle; run is ignored in LOAD.
REQ-023 FETCH: mem_addr = stall ? inst_pc : fetch_pc (combinational); mem_we=0.
REQ-024 FETCH, no stall, no branch: fetch_pc<=fetch_pc+1 modulo 2^MEM_SPACE, inst_pc<=fetch_pc, inst_valid<=1.
REQ-025 inst SHALL equal mem_rdata directly; instruction at inst_pc is valid when inst_valid=1.
REQ-026 stall=1 without br_taken: fetch_pc, inst_pc, inst_valid hold; mem re-reads inst_pc so inst stays stable.
REQ-027 br_taken=1 (priority over stall and halt): fetch_pc<=br_target, inst_valid<=0; first redirected instruction valid 2 cycles after br_taken.
REQ-028 inst_valid=1, no stall, no br_taken, inst opcode==HALT_OP: state -> HALT, inst_valid<=0, fetch_pc<=inst_pc.
REQ-029 FETCH with run==0 -> IDLE, inst_valid<=0, fetch_pc retained so a later run resumes there.
REQ-030 HALT: halted=1, inst_valid=0; run==0 -> IDLE; load_start -> LOAD.
REQ-031 load_start in FETCH SHALL be ignored; only IDLE or HALT honour it.

Reset
REQ-032 rst==0 SHALL immediately force IDLE, fetch_pc=0, inst_pc=0, counter=0, inst_valid=0, load_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0, busy_load=0.
REQ-033 Reset mid-LOAD or mid-FETCH SHALL abandon the operation with no further memory write after rst falls.

Verification
REQ-034 Load 4 words 16'h1111..16'h4444, last on 4th -> mem_we writes addresses 0..3, then IDLE, busy_load=0.
REQ-035 Load, run=1 -> inst_valid rises cycle 2 with inst_pc=0, then inst_pc 1,2,3 on consecutive cycles.
REQ-036 stall=1 for 3 cycles at inst_pc=2 -> inst_pc=2, inst constant, inst_valid=1 throughout; resumes at 3.
REQ-037 br_taken with br_target=8'h40 and stall=1 same cycle -> one bubble, then inst_pc=8'h40 valid.
REQ-038 Word 16'hF000 at address 5 -> HALT after inst_pc=5 presented, halted=1; run=0 -> IDLE.
REQ-039 Load 256 words with no load_last (MEM_SPACE=8) -> exits after address 8'hFF; rst=0 mid-LOAD -> mem_we=0 at once.
